// File: rtl/l2_home_stub_pkg.sv
// Shared coherence-message encodings and field widths for the L2 <-> home stub channel.
package l2_home_stub_pkg;

  localparam int REQ_MSG_W = 3;
  localparam int RSP_MSG_W = 2;
  localparam int HPROT_W   = 2;
  localparam int INVACK_W  = 4;
  localparam int STAT_W    = 16;
  localparam int DELAY_W   = 8;

  localparam logic [REQ_MSG_W-1:0] REQ_GETS = 3'b000;
  localparam logic [REQ_MSG_W-1:0] REQ_GETM = 3'b001;
  localparam logic [REQ_MSG_W-1:0] REQ_PUTS = 3'b010;
  localparam logic [REQ_MSG_W-1:0] REQ_PUTM = 3'b011;

  localparam logic [RSP_MSG_W-1:0] RSP_DATA    = 2'b00;
  localparam logic [RSP_MSG_W-1:0] RSP_EDATA   = 2'b01;
  localparam logic [RSP_MSG_W-1:0] RSP_INV_ACK = 2'b10;
  localparam logic [RSP_MSG_W-1:0] RSP_PUT_ACK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic stat_inc_ok(input logic [STAT_W-1:0] cnt);
    return cnt != {STAT_W{1'b1}};
  endfunction

endpackage

// File: rtl/l2_home_stub_mem.sv
// Flop-based line memory with per-line owned bits; combinational read, synchronous update.
module l2_home_stub_mem #(
  parameter int LINE_BITS    = 128,
  parameter int MEM_IDX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEM_IDX_BITS-1:0] idx,
  output logic [LINE_BITS-1:0]    rd_line,
  output logic                    rd_owned,
  input  logic                    wr_en,
  input  logic [LINE_BITS-1:0]    wr_line,
  input  logic                    own_set,
  input  logic                    own_clr
);

  localparam int DEPTH = 1 << MEM_IDX_BITS;

  logic [LINE_BITS-1:0] lines [DEPTH];
  logic [DEPTH-1:0]     owned;

  // Whole array clears on reset so an aborted transaction leaves no stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) lines[i] <= '0;
      owned <= '0;
    end else begin
      if (wr_en) lines[idx] <= wr_line;
      if (own_set) owned[idx] <= 1'b1;
      else if (own_clr) owned[idx] <= 1'b0;
    end
  end

  assign rd_line  = lines[idx];
  assign rd_owned = owned[idx];

endmodule

// File: rtl/l2_home_stub.sv
// Home-side responder stub for the L2 request channel; single outstanding request.
// Optional request statistics counters enabled by L2_HOME_STUB_STATS_EN.
module l2_home_stub
  import l2_home_stub_pkg::*;
#(
  parameter int LINE_ADDR_BITS = 28,
  parameter int LINE_BITS      = 128,
  parameter int MEM_IDX_BITS   = 6,
  parameter int RSP_DELAY      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [REQ_MSG_W-1:0]      req_coh_msg,
  input  logic [HPROT_W-1:0]        req_hprot,
  input  logic [LINE_ADDR_BITS-1:0] req_addr,
  input  logic [LINE_BITS-1:0]      req_line,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RSP_MSG_W-1:0]      rsp_coh_msg,
  output logic [LINE_ADDR_BITS-1:0] rsp_addr,
  output logic [LINE_BITS-1:0]      rsp_line,
  output logic [INVACK_W-1:0]       rsp_invack_cnt,
  output logic [LINE_BITS/64-1:0]   rsp_word_mask,
  output logic                      proto_err
`ifdef L2_HOME_STUB_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_gets,
  output logic [STAT_W-1:0]         stat_getm,
  output logic [STAT_W-1:0]         stat_puts,
  output logic [STAT_W-1:0]         stat_putm
`endif
);

  localparam int                 WMASK_W    = LINE_BITS / 64;
  localparam logic [DELAY_W-1:0] DELAY_INIT = DELAY_W'(RSP_DELAY - 1);

  state_t                   state;
  logic [DELAY_W-1:0]       cnt;
  logic [HPROT_W-1:0]       hprot_q;
  logic                     capture;
  logic [MEM_IDX_BITS-1:0]  idx;
  logic [LINE_BITS-1:0]     mem_line;
  logic                     mem_owned;
  logic [RSP_MSG_W-1:0]     dec_msg;
  logic                     dec_data;
  logic                     dec_err;
  logic                     dec_wr;
  logic                     dec_set;
  logic                     dec_clr;

  assign idx     = req_addr[MEM_IDX_BITS-1:0];
  assign capture = (state == ST_IDLE) && req_valid && req_ready;

  always_comb begin
    dec_msg  = RSP_PUT_ACK;
    dec_data = 1'b0;
    dec_err  = 1'b0;
    dec_wr   = 1'b0;
    dec_set  = 1'b0;
    dec_clr  = 1'b0;
    case (req_coh_msg)
      REQ_GETS: begin dec_msg = RSP_EDATA; dec_data = 1'b1; dec_set = 1'b1; dec_err = mem_owned; end
      REQ_GETM: begin dec_msg = RSP_DATA;  dec_data = 1'b1; dec_set = 1'b1; dec_err = mem_owned; end
      REQ_PUTS: begin dec_clr = 1'b1; dec_err = !mem_owned; end
      REQ_PUTM: begin dec_wr = 1'b1; dec_clr = 1'b1; dec_err = !mem_owned; end
      default:  dec_err = 1'b1;  // reserved 1xx: ack only, state untouched
    endcase
  end

  l2_home_stub_mem #(
    .LINE_BITS    (LINE_BITS),
    .MEM_IDX_BITS (MEM_IDX_BITS)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .rd_line  (mem_line),
    .rd_owned (mem_owned),
    .wr_en    (capture && dec_wr),
    .wr_line  (req_line),
    .own_set  (capture && dec_set),
    .own_clr  (capture && dec_clr)
  );

  assign rsp_invack_cnt = '0;

  // With RSP_DELAY=1 SEND is entered directly and rsp_valid rises one cycle later,
  // keeping the capture-to-valid latency equal to RSP_DELAY for every setting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hprot_q       <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_coh_msg   <= '0;
      rsp_addr      <= '0;
      rsp_line      <= '0;
      rsp_word_mask <= '0;
      proto_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            rsp_coh_msg   <= dec_msg;
            rsp_addr      <= req_addr;
            rsp_line      <= dec_data ? mem_line : '0;
            rsp_word_mask <= dec_data ? {WMASK_W{1'b1}} : '0;
            hprot_q       <= req_hprot;
            cnt           <= DELAY_INIT;
            req_ready     <= 1'b0;
            if (dec_err) proto_err <= 1'b1;
            state <= (RSP_DELAY == 1) ? ST_SEND : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_SEND;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SEND: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef L2_HOME_STUB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_gets <= '0;
      stat_getm <= '0;
      stat_puts <= '0;
      stat_putm <= '0;
    end else if (capture) begin
      if (req_coh_msg == REQ_GETS && stat_inc_ok(stat_gets)) stat_gets <= stat_gets + 1'b1;
      if (req_coh_msg == REQ_GETM && stat_inc_ok(stat_getm)) stat_getm <= stat_getm + 1'b1;
      if (req_coh_msg == REQ_PUTS && stat_inc_ok(stat_puts)) stat_puts <= stat_puts + 1'b1;
      if (req_coh_msg == REQ_PUTM && stat_inc_ok(stat_putm)) stat_putm <= stat_putm + 1'b1;
    end
  end
`endif

endmodule

// File: doc/l2_home_stub.md
Name: l2_home_stub

Overview:
- Home-side responder for the L2 coherence request channel: accepts L2 req_out messages (GetS/GetM/PutS/PutM) and returns rsp_in messages (EData/Data/PutAck).
- Backed by a small flop-based line memory with per-line ownership tracking.
- Used as the LLC stand-in for L2 unit/integration benches and single-tile bring-up, connected directly to the L2 req_out/rsp_in handshakes.
- Single outstanding request; never issues forwards.

Parameters:
- LINE_ADDR_BITS, 28, width of line address.
- LINE_BITS, 128, bits per cache line.
- MEM_IDX_BITS, 6, line-memory index width (depth 64); index = addr[MEM_IDX_BITS-1:0].
- RSP_DELAY, 4, response latency in cycles from request capture to rsp_valid; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid  in  1  L2 req_out valid
- req_ready  out  1  stub accepts request
- req_coh_msg  in  3  GetS=000, GetM=001, PutS=010, PutM=011
- req_hprot  in  2  ignored except captured for debug
- req_addr  in  LINE_ADDR_BITS  line address
- req_line  in  LINE_BITS  writeback data (PutM)
- rsp_valid  out  1  L2 rsp_in valid
- rsp_ready  in  1  L2 accepts response
- rsp_coh_msg  out  2  Data=00, EData=01, InvAck=10, PutAck=11
- rsp_addr  out  LINE_ADDR_BITS  echoed request address
- rsp_line  out  LINE_BITS  line data (zero for PutAck)
- rsp_invack_cnt  out  4  always 0
- rsp_word_mask  out  LINE_BITS/64  all ones for data, zero for PutAck
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=0, async): FSM=IDLE; req_ready=1, rsp_valid=0, all rsp_* fields 0, proto_err=0, delay counter 0, all owned bits 0, all memory lines 0.
- FSM states: IDLE, WAIT, SEND.
- IDLE: req_ready=1. On req_valid&req_ready, capture msg/addr and set counter=RSP_DELAY-1. Go to SEND if RSP_DELAY=1, else WAIT.
- Capture actions by message:
  - GetS: rsp=EData, line=mem[idx]; set owned[idx].
  - GetM: rsp=Data, line=mem[idx]; set owned[idx].
  - PutS: rsp=PutAck; clear owned[idx].
  - PutM: mem[idx]<=req_line; rsp=PutAck; clear owned[idx].
- Protocol errors (set proto_err, sticky until reset; response still sent normally):
  - GetS/GetM to an already-owned idx.
  - PutM/PutS to a non-owned idx.
  - Reserved coh_msg 1xx: respond PutAck, no memory or owner change.
- WAIT: req_ready=0; decrement counter each cycle; go to SEND when counter=0 (registered). rsp_valid asserts exactly RSP_DELAY cycles after the capture edge.
- SEND: rsp_valid=1, fields stable until rsp_ready. On handshake: rsp_valid=0, return to IDLE. req_ready reasserts the next cycle, so back-to-back throughput is at most 1 request per RSP_DELAY+2 cycles.
- Aliasing: idx ignores upper address bits. Two addresses with the same low bits alias; this is documented, not flagged.
- rsp_ready held high before SEND has no effect. req_valid deasserted mid-WAIT has no effect (request already captured).
- Reset asserted mid-transaction aborts it: no response is sent, memory returns to zero.

Optional Feature:
- Macro: L2_HOME_STUB_STATS_EN.
- When defined, adds outputs stat_gets, stat_getm, stat_puts, stat_putm (each 16 bit). Each increments on request capture of its type, saturates at 0xFFFF, and resets to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds the coh_msg encodings (REQ_GETS..REQ_PUTM, RSP_DATA..RSP_PUT_ACK) and the req/rsp field widths, so L2 and the stub agree on encodings.
- One sub-module, l2_home_stub_mem: line memory plus owned bits. It has a synchronous write and a combinational read on the capture cycle.

Test Plan:
- Reset, then GetS addr 0x10 with RSP_DELAY=4 -> rsp_valid exactly 4 cycles after capture; EData, addr 0x10, line 0, mask all ones, invack 0.
- PutM addr 0x10 line 0xA5..A5 (after GetS) -> PutAck. Then GetM 0x10 -> Data with line 0xA5..A5, proto_err stays 0.
- GetS 0x05 twice without a Put -> second response still EData; proto_err=1 and stays 1 until rst.
- Hold rsp_ready=0 for 10 cycles in SEND -> rsp fields stable and req_ready=0 throughout; ready=1 -> IDLE the next cycle.
- Assert rst low during WAIT -> rsp_valid never asserts, req_ready=1 immediately, subsequent GetS returns line 0.
- With L2_HOME_STUB_STATS_EN: issue 3 GetS, 2 PutM -> stat_gets=3, stat_putm=2, others 0.
